// File: rtl/de_issue_seq_pkg.sv
// de_issue_seq_pkg: shared definitions for the Raisin64 fetch-to-decode issue
// sequencer.
//   PARCEL_W        width of one instruction parcel in bits
//   LEN_16/32/64    instruction length codes as presented on id_len
//   seq_state_e     sequencer states (ST_RUN, ST_TRAP)
//   len_to_parcels  maps a length code to its size in parcels
package de_issue_seq_pkg;

    localparam int PARCEL_W = 16;

    localparam logic [1:0] LEN_16 = 2'd0;
    localparam logic [1:0] LEN_32 = 2'd1;
    localparam logic [1:0] LEN_64 = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } seq_state_e;

    function automatic logic [2:0] len_to_parcels(input logic [1:0] len_code);
        logic [2:0] parcels;
        case (len_code)
            LEN_16:  parcels = 3'd1;
            LEN_32:  parcels = 3'd2;
            LEN_64:  parcels = 3'd4;
            default: parcels = 3'd1;
        endcase
        return parcels;
    endfunction

endpackage

// File: rtl/de_len_decode.sv
// de_len_decode: instruction length decode from the head parcel (combinational).
// Ports:
//   head_parcel  in   first parcel of the instruction
//   len_code     out  LEN_16 / LEN_32 / LEN_64
//   len_parcels  out  instruction size in parcels (1, 2 or 4)
module de_len_decode
    import de_issue_seq_pkg::*;
(
    input  logic [PARCEL_W-1:0] head_parcel,
    output logic [1:0]          len_code,
    output logic [2:0]          len_parcels
);

    // Only the two top bits carry the length; the rest is opcode payload.
    logic payload_unused_s;
    assign payload_unused_s = ^head_parcel[PARCEL_W-3:0];

    // Length classification from the top two bits of the parcel.
    always_comb begin
        len_code = LEN_16;
        case (head_parcel[PARCEL_W-1 -: 2])
            2'b00:   len_code = LEN_16;
            2'b01:   len_code = LEN_16;
            2'b10:   len_code = LEN_32;
            2'b11:   len_code = LEN_64;
            default: len_code = LEN_16;
        endcase
        len_parcels = len_to_parcels(len_code);
    end

endmodule

// File: rtl/de_issue_seq.sv
// de_issue_seq: Raisin64 fetch-to-decode issue sequencer.
// Buffers aligned 64-bit fetch words as 16-bit parcels (8 parcels max),
// extracts 16/32/64-bit instructions, left-justifies them for decode, and
// traps when the decode bad-opcode check fires on a complete head.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fw_data/valid/ready   fetch word input handshake
//   flush, flush_pc       redirect: drop all buffered state, restart at flush_pc
//   chk_opcode, chk_bad   head instruction to the bad-opcode check and its verdict
//   id_inst/len/pc        issued instruction, length code and byte address
//   id_valid, id_ready    decode handshake
//   trap_valid, trap_pc   bad-opcode trap, held until flush
// Optional: DE_ISSUE_SEQ_PERF_EN adds perf_issued, perf_bubbles, perf_traps.
module de_issue_seq
    import de_issue_seq_pkg::*;
#(
    parameter int PC_W   = 64,
    parameter int PERF_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      fw_data,
    input  logic             fw_valid,
    output logic             fw_ready,
    input  logic             flush,
    input  logic [PC_W-1:0]  flush_pc,
    output logic [63:0]      chk_opcode,
    input  logic             chk_bad,
    output logic [63:0]      id_inst,
    output logic [1:0]       id_len,
    output logic [PC_W-1:0]  id_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic             trap_valid,
    output logic [PC_W-1:0]  trap_pc
`ifdef DE_ISSUE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_bubbles,
    output logic [PERF_W-1:0] perf_traps
`endif
);

    localparam int BUF_W = 8 * PARCEL_W;

    logic [BUF_W-1:0]    buf_r, buf_next_s, shifted_s, ins_s;
    logic [63:0]         word_al_s, head_just_s;
    logic [3:0]          cnt_r, cnt_next_s, cnt_after_s, fill_s;
    logic [1:0]          skip_r, skip_next_s;
    logic [PC_W-1:0]     pc_r, pc_next_s, trap_pc_r, trap_pc_next_s;
    seq_state_e          state_r, state_next_s;
    logic [1:0]          len_code_s;
    logic [2:0]          len_parcels_s;
    logic                run_s, head_complete_s, accept_s, issue_s, trap_hit_s;
    logic                flush_pc_unused_s;

    // Byte bit 0 of the redirect target is meaningless for parcel addressing.
    assign flush_pc_unused_s = flush_pc[0];

    de_len_decode u_len_decode (
        .head_parcel (buf_r[BUF_W-1 -: PARCEL_W]),
        .len_code    (len_code_s),
        .len_parcels (len_parcels_s)
    );

    assign run_s           = (state_r == ST_RUN);
    assign head_complete_s = (cnt_r >= {1'b0, len_parcels_s});
    assign fw_ready        = run_s && (cnt_r <= 4'd4) && !flush;
    assign accept_s        = fw_valid && fw_ready;
    assign id_valid        = run_s && head_complete_s && !chk_bad && !flush;
    assign issue_s         = id_valid && id_ready;
    assign trap_hit_s      = run_s && head_complete_s && chk_bad && !flush;

    // Left-justified head instruction, zero-filled past its own length.
    always_comb begin
        head_just_s = 64'h0;
        case (len_code_s)
            LEN_16:  head_just_s = {buf_r[BUF_W-1 -: 16], 48'h0};
            LEN_32:  head_just_s = {buf_r[BUF_W-1 -: 32], 32'h0};
            LEN_64:  head_just_s = buf_r[BUF_W-1 -: 64];
            default: head_just_s = 64'h0;
        endcase
    end

    assign chk_opcode = head_just_s;
    assign id_inst    = head_just_s;
    assign id_len     = len_code_s;
    assign id_pc      = pc_r;
    assign trap_valid = (state_r == ST_TRAP);
    assign trap_pc    = trap_pc_r;

    // Parcel buffer datapath: issue shift, then append the (skip-trimmed) word
    // directly behind whatever survives the shift. Parcels past the count are
    // kept zero so the OR-merge is safe.
    always_comb begin
        shifted_s   = buf_r;
        cnt_after_s = cnt_r;
        if (issue_s) begin
            shifted_s   = buf_r << {len_parcels_s, 4'b0000};
            cnt_after_s = cnt_r - {1'b0, len_parcels_s};
        end else begin
            shifted_s   = buf_r;
            cnt_after_s = cnt_r;
        end
        word_al_s = fw_data << {skip_r, 4'b0000};
        ins_s     = {word_al_s, 64'h0} >> {cnt_after_s, 4'b0000};
        fill_s    = 4'd4 - {2'b00, skip_r};

        buf_next_s     = shifted_s;
        cnt_next_s     = cnt_after_s;
        skip_next_s    = skip_r;
        pc_next_s      = pc_r;
        trap_pc_next_s = trap_pc_r;
        if (flush) begin
            buf_next_s  = {BUF_W{1'b0}};
            cnt_next_s  = 4'd0;
            skip_next_s = flush_pc[2:1];
            pc_next_s   = {flush_pc[PC_W-1:1], 1'b0};
        end else begin
            if (accept_s) begin
                buf_next_s  = shifted_s | ins_s;
                cnt_next_s  = cnt_after_s + fill_s;
                skip_next_s = 2'b00;
            end else begin
                buf_next_s  = shifted_s;
                cnt_next_s  = cnt_after_s;
                skip_next_s = skip_r;
            end
            if (issue_s) begin
                pc_next_s = pc_r + {{(PC_W-4){1'b0}}, len_parcels_s, 1'b0};
            end else begin
                pc_next_s = pc_r;
            end
            if (trap_hit_s) begin
                trap_pc_next_s = pc_r;
            end else begin
                trap_pc_next_s = trap_pc_r;
            end
        end
    end

    // Sequencer next-state: a complete bad head traps, only flush leaves TRAP.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (trap_hit_s) begin
                    state_next_s = ST_TRAP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (flush) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_TRAP;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            buf_r     <= {BUF_W{1'b0}};
            cnt_r     <= 4'd0;
            skip_r    <= 2'b00;
            pc_r      <= {PC_W{1'b0}};
            trap_pc_r <= {PC_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            buf_r     <= buf_next_s;
            cnt_r     <= cnt_next_s;
            skip_r    <= skip_next_s;
            pc_r      <= pc_next_s;
            trap_pc_r <= trap_pc_next_s;
        end
    end

`ifdef DE_ISSUE_SEQ_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic bubble_s;
    assign bubble_s = run_s && id_ready && !id_valid;

    // Saturating event counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= {PERF_W{1'b0}};
            perf_bubbles <= {PERF_W{1'b0}};
            perf_traps   <= {PERF_W{1'b0}};
        end else begin
            if (issue_s && (perf_issued != PERF_MAX)) begin
                perf_issued <= perf_issued + PERF_ONE;
            end
            if (bubble_s && (perf_bubbles != PERF_MAX)) begin
                perf_bubbles <= perf_bubbles + PERF_ONE;
            end
            if (trap_hit_s && (perf_traps != PERF_MAX)) begin
                perf_traps <= perf_traps + PERF_ONE;
            end
        end
    end
`else
    logic [PERF_W-1:0] perf_unused_s;
    assign perf_unused_s = {PERF_W{1'b0}};
`endif

endmodule
